// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {CS,RAS,CAS,WE}, one-hot FSM
// states, precharge exit kinds and default timing constants.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_REQ  = 5'b00010;
  localparam logic [4:0] ST_ACT  = 5'b00100;
  localparam logic [4:0] ST_WR   = 5'b01000;
  localparam logic [4:0] ST_PRE  = 5'b10000;

  localparam int DEF_BL    = 4;
  localparam int DEF_T_RCD = 3;
  localparam int DEF_T_RP  = 3;

  // What happens when a precharge finishes.
  typedef enum logic [1:0] {
    PK_DONE    = 2'd0,
    PK_SUSPEND = 2'd1,
    PK_ROW     = 2'd2
  } pre_kind_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Write address tracker: bank/row/column position and remaining-burst count,
// advanced by one burst per step, with the column-wrap lookahead flag.
module sdram_addr_gen
  import sdram_pkg::*;
#(
  parameter int ROW_W = 12,
  parameter int COL_W = 9,
  parameter int BL    = DEF_BL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       bank_in,
  input  logic [ROW_W-1:0] row_in,
  input  logic [COL_W-1:0] col_in,
  input  logic [15:0]      len_in,
  output logic [1:0]       bank,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [COL_W-1:0] col_next,
  output logic             wrap,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_STEP = COL_W'(BL);

  logic [15:0] rem;

  assign col_next = col + COL_STEP;
  assign wrap     = (col_next == '0);
  assign last     = (rem == 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
      row  <= '0;
      col  <= '0;
      rem  <= '0;
    end else if (load) begin
      bank <= bank_in;
      row  <= row_in;
      col  <= col_in;
      rem  <= len_in;
    end else if (step) begin
      // Bank stays fixed; a column wrap moves on to the next row.
      col <= col_next;
      if (wrap) row <= row + 1'b1;
      rem <= rem - 16'd1;
    end
  end

endmodule

// File: rtl/sdram_write_burst.sv
// SDRAM write-burst engine: streams FIFO words into open rows as BL-word WR
// bursts, handling bus arbitration, row changes and refresh suspension.
module sdram_write_burst
  import sdram_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ROW_W = 12,
  parameter int COL_W = 9,
  parameter int BL    = DEF_BL,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_trig,
  input  logic [1:0]       start_bank,
  input  logic [ROW_W-1:0] start_row,
  input  logic [COL_W-1:0] start_col,
  input  logic [15:0]      wr_len,
  output logic             wr_req,
  input  logic             wr_en,
  input  logic             ref_req,
  output logic             flag_wr_end,
  output logic             done,
  output logic             busy,
  input  logic             din_avail,
  input  logic [DW-1:0]    din,
  output logic             din_rd,
  output logic [3:0]       wr_cmd,
  output logic [ROW_W-1:0] wr_addr,
  output logic [1:0]       bank_addr,
  output logic [DW-1:0]    wr_data
);

  localparam logic [ROW_W-1:0] ALL_BANKS = ROW_W'(1) << 10;

  logic [4:0]       state;
  pre_kind_t        kind;
  pre_kind_t        pre_nxt;
  logic [7:0]       tcnt;
  logic [3:0]       beat;
  logic             in_burst;
  logic             burst_end;
  logic             start;
  logic             pre_go;
  logic             load;
  logic             step;
  logic [COL_W-1:0] start_col_sel;

  logic [1:0]       bank;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_next;
  logic             wrap;
  logic             last;

  function automatic logic [ROW_W-1:0] col_addr(input logic [COL_W-1:0] c);
    logic [ROW_W-1:0] a;
    a     = ROW_W'(c);
    a[10] = 1'b0;
    return a;
  endfunction

  assign wr_req    = (state == ST_REQ);
  assign burst_end = in_burst && (beat == 4'(BL - 1));
  assign load      = (state == ST_IDLE) && wr_trig && (wr_len != 16'd0);
  assign step      = (state == ST_WR) && burst_end;

  sdram_addr_gen #(
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .BL    (BL)
  ) u_addr (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .step     (step),
    .bank_in  (start_bank),
    .row_in   (start_row),
    .col_in   (start_col),
    .len_in   (wr_len),
    .bank     (bank),
    .row      (row),
    .col      (col),
    .col_next (col_next),
    .wrap     (wrap),
    .last     (last)
  );

  // Burst-boundary decisions: bursts are never split, and refresh is only
  // honoured between bursts or while starved for data.
  always_comb begin
    start         = 1'b0;
    start_col_sel = col;
    pre_go        = 1'b0;
    pre_nxt       = PK_DONE;
    case (state)
      ST_ACT: start = (tcnt == 8'(T_RCD)) && din_avail;
      ST_WR: begin
        if (burst_end) begin
          if (last) begin
            pre_go = 1'b1;
          end else if (ref_req) begin
            pre_go  = 1'b1;
            pre_nxt = PK_SUSPEND;
          end else if (wrap) begin
            pre_go  = 1'b1;
            pre_nxt = PK_ROW;
          end else begin
            start         = din_avail;
            start_col_sel = col_next;
          end
        end else if (!in_burst) begin
          if (ref_req) begin
            pre_go  = 1'b1;
            pre_nxt = PK_SUSPEND;
          end else begin
            start = din_avail;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      kind        <= PK_DONE;
      tcnt        <= '0;
      beat        <= '0;
      in_burst    <= 1'b0;
      wr_cmd      <= CMD_NOP;
      wr_addr     <= '0;
      bank_addr   <= '0;
      wr_data     <= '0;
      din_rd      <= 1'b0;
      done        <= 1'b0;
      flag_wr_end <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_cmd      <= CMD_NOP;
      din_rd      <= 1'b0;
      done        <= 1'b0;
      flag_wr_end <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (load) begin
            state <= ST_REQ;
            busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (wr_en) begin
            state     <= ST_ACT;
            wr_cmd    <= CMD_ACT;
            wr_addr   <= row;
            bank_addr <= bank;
            tcnt      <= 8'd1;
          end
        end
        ST_ACT: begin
          if (tcnt == 8'(T_RCD)) begin
            state <= ST_WR;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ST_PRE: begin
          if (tcnt == 8'(T_RP)) begin
            tcnt <= '0;
            case (kind)
              PK_DONE: begin
                state       <= ST_IDLE;
                done        <= 1'b1;
                flag_wr_end <= 1'b1;
                busy        <= 1'b0;
              end
              PK_SUSPEND: begin
                state       <= ST_REQ;
                flag_wr_end <= 1'b1;
              end
              default: begin
                state     <= ST_ACT;
                wr_cmd    <= CMD_ACT;
                wr_addr   <= row;
                bank_addr <= bank;
                tcnt      <= 8'd1;
              end
            endcase
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ST_WR: ;
        default: state <= ST_IDLE;
      endcase

      // Data beats: wr_data captures din at the start of every beat, so the
      // first word sits on the bus in the same cycle as the WR command.
      if (start) begin
        wr_cmd    <= CMD_WR;
        wr_addr   <= col_addr(start_col_sel);
        bank_addr <= bank;
        din_rd    <= 1'b1;
        wr_data   <= din;
        in_burst  <= 1'b1;
        beat      <= '0;
      end else if (burst_end) begin
        in_burst <= 1'b0;
        beat     <= '0;
      end else if (in_burst) begin
        beat    <= beat + 4'd1;
        din_rd  <= 1'b1;
        wr_data <= din;
      end

      if (pre_go) begin
        state   <= ST_PRE;
        wr_cmd  <= CMD_PRE;
        wr_addr <= ALL_BANKS;
        kind    <= pre_nxt;
        tcnt    <= 8'd1;
      end
    end
  end

endmodule
